// File: rtl/otn_pkg.sv
// Shared definitions for the serial OTN link: frame FSM states, framing
// constants and the bit-serial CRC-8 step used by both link ends.
package otn_pkg;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    SEQ   = 3'd1,
    PAY   = 3'd2,
    CRCB  = 3'd3,
    CHECK = 3'd4
  } state_e;

  localparam int          FAS_W    = 16;
  localparam int          SEQ_W    = 8;
  localparam int          CRC_W    = 8;
  localparam int          BYTE_W   = 8;
  localparam logic [15:0] FAS      = 16'hF628;
  localparam logic [7:0]  CRC_POLY = 8'h07;

  // MSB-first CRC-8 step: shift left, fold in the polynomial on feedback.
  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic b);
    logic [7:0] poly_s;
    poly_s   = (crc[7] ^ b) ? CRC_POLY : 8'h00;
    crc8_bit = {crc[6:0], 1'b0} ^ poly_s;
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator with synchronous clear and update enable.
module crc8_serial
  import otn_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;

  // CRC register: clear has priority over update
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      crc_q <= 8'h00;
    end else if (en_i) begin
      crc_q <= crc8_bit(crc_q, bit_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/otn_deframer.sv
// Receive end of the serial OTN link: FAS hunt, field capture, CRC check,
// payload buffering with a valid/ready drain, and the ARQ acknowledge pulse.
module otn_deframer
  import otn_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 4,
  parameter int ACK_LEN       = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_otn_tx_data,
  input  logic       i_arq_en,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  input  logic       i_data_ready,
  output logic [7:0] o_crc_val,
  output logic       o_crc_err,
  output logic       o_overrun,
  output logic       o_otn_rx_ack
);

  localparam int PAY_BITS = PAYLOAD_BYTES * BYTE_W;
  localparam int CNT_W    = $clog2((PAY_BITS > SEQ_W) ? PAY_BITS : SEQ_W);
  localparam int IDX_W    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int ACK_W    = $clog2(ACK_LEN + 1);

  state_e             state_q, state_d;
  logic [FAS_W-2:0]   sreg_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEQ_W-1:0]   seq_q, last_seq_q;
  logic               last_seq_vld_q;
  logic [6:0]         shift_q;
  logic [CRC_W-1:0]   rx_crc_q, crc_s, crc_val_q;
  logic [7:0]         stage_q [PAYLOAD_BYTES];
  logic [7:0]         buf_q   [PAYLOAD_BYTES];
  logic               crc_err_q, overrun_q, ack_req_q, start_q, busy_q, valid_q;
  logic [IDX_W-1:0]   rd_idx_q;
  logic [7:0]         data_q;
  logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
  logic               ack_q;
  logic               fas_hit_s, good_s, dup_s, chk_s, load_s, ack_req_s, xfer_s;
  logic [IDX_W-1:0]   byte_idx_s;

  assign fas_hit_s  = ({sreg_q, i_otn_tx_data} == FAS);
  assign chk_s      = (state_q == CHECK);
  assign good_s     = (rx_crc_q == crc_s);
  assign dup_s      = i_arq_en && last_seq_vld_q && (seq_q == last_seq_q);
  assign load_s     = chk_s && good_s && !dup_s && !busy_q;
  assign ack_req_s  = chk_s && good_s && (dup_s || (!busy_q && i_arq_en));
  assign xfer_s     = valid_q && i_data_ready;
  assign byte_idx_s = IDX_W'(cnt_q >> 3);

  crc8_serial u_crc (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .clr_i (state_q == HUNT),
    .en_i  ((state_q == SEQ) || (state_q == PAY)),
    .bit_i (i_otn_tx_data),
    .crc_o (crc_s)
  );

  // Frame FSM next state and field bit counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      HUNT:  if (fas_hit_s) state_d = SEQ; else state_d = HUNT;
      SEQ:   if (cnt_q == CNT_W'(SEQ_W - 1)) state_d = PAY; else state_d = SEQ;
      PAY:   if (cnt_q == CNT_W'(PAY_BITS - 1)) state_d = CRCB; else state_d = PAY;
      CRCB:  if (cnt_q == CNT_W'(CRC_W - 1)) state_d = CHECK; else state_d = CRCB;
      CHECK: state_d = HUNT;
      default: state_d = HUNT;
    endcase
    if ((state_d != state_q) || (state_q == HUNT) || (state_q == CHECK)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Frame FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= HUNT;
    else       state_q <= state_d;
  end

  // Field capture and frame verdict
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sreg_q         <= '0;
      cnt_q          <= '0;
      seq_q          <= '0;
      shift_q        <= '0;
      rx_crc_q       <= '0;
      last_seq_q     <= '0;
      last_seq_vld_q <= 1'b0;
      crc_val_q      <= '0;
      crc_err_q      <= 1'b0;
      overrun_q      <= 1'b0;
      ack_req_q      <= 1'b0;
      for (int i = 0; i < PAYLOAD_BYTES; i++) stage_q[i] <= 8'h00;
    end else begin
      sreg_q    <= {sreg_q[FAS_W-3:0], i_otn_tx_data};
      cnt_q     <= cnt_d;
      crc_err_q <= chk_s && !good_s;
      overrun_q <= chk_s && good_s && !dup_s && busy_q;
      ack_req_q <= ack_req_s;
      if (state_q == SEQ) seq_q <= {seq_q[SEQ_W-2:0], i_otn_tx_data};
      if (state_q == PAY) begin
        shift_q <= {shift_q[5:0], i_otn_tx_data};
        if (cnt_q[2:0] == 3'd7) stage_q[byte_idx_s] <= {shift_q, i_otn_tx_data};
      end
      if (state_q == CRCB) rx_crc_q <= {rx_crc_q[CRC_W-2:0], i_otn_tx_data};
      if (chk_s) crc_val_q <= crc_s;
      if (load_s) begin
        last_seq_q     <= seq_q;
        last_seq_vld_q <= 1'b1;
      end
    end
  end

  // Output buffer and valid/ready drain; busy spans load to final transfer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      rd_idx_q <= '0;
      for (int i = 0; i < PAYLOAD_BYTES; i++) buf_q[i] <= 8'h00;
    end else begin
      start_q <= load_s;
      if (load_s) begin
        buf_q  <= stage_q;
        busy_q <= 1'b1;
      end
      if (start_q) begin
        valid_q  <= 1'b1;
        data_q   <= buf_q[0];
        rd_idx_q <= '0;
      end else if (xfer_s) begin
        if (rd_idx_q == IDX_W'(PAYLOAD_BYTES - 1)) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end else begin
          rd_idx_q <= rd_idx_q + IDX_W'(1);
          data_q   <= buf_q[rd_idx_q + IDX_W'(1)];
        end
      end
    end
  end

  // Ack timer; a new request reloads the full length
  always_comb begin
    ack_cnt_d = ack_cnt_q;
    if (ack_req_q) begin
      ack_cnt_d = ACK_W'(ACK_LEN);
    end else if (ack_cnt_q != '0) begin
      ack_cnt_d = ack_cnt_q - ACK_W'(1);
    end else begin
      ack_cnt_d = '0;
    end
  end

  // Ack line register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_cnt_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      ack_cnt_q <= ack_cnt_d;
      ack_q     <= (ack_cnt_d != '0);
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_crc_val    = crc_val_q;
  assign o_crc_err    = crc_err_q;
  assign o_overrun    = overrun_q;
  assign o_otn_rx_ack = ack_q;

endmodule
